shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer.sv | 102 ++++++++++
 tb/tb_shift_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Load-and-shift sequencer for a 74194-style register: LOAD, N shift steps, CAPTURE; DONE lands N+3 cycles after START.
// No backpressure: START is ignored while BUSY, and a START in the DONE cycle begins the next operation at once.
module shift_sequencer (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [3:0] i_din,
    input  logic       i_dir,
    input  logic [2:0] i_count,
    input  logic [3:0] i_q,
    output logic [1:0] o_s,
    output logic [3:0] o_d,
    output logic       o_oe,
    output logic       o_busy,
    output logic       o_done,
    output logic [3:0] o_result
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    localparam logic [1:0] S_HOLD  = 2'b00;
    localparam logic [1:0] S_RIGHT = 2'b01;
    localparam logic [1:0] S_LEFT  = 2'b10;
    localparam logic [1:0] S_LOAD  = 2'b11;

    state_t     r_state;
    state_t     w_state_next;
    logic       r_dir;
    logic [2:0] r_count;
    logic [2:0] r_cnt;
    logic       w_accept;
    logic [1:0] w_s_next;
    logic       w_active_next;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD:    w_state_next = (r_count != 3'd0) ? ST_SHIFT : ST_CAPTURE;
            ST_SHIFT:   w_state_next = (r_cnt == 3'd1) ? ST_CAPTURE : ST_SHIFT;
            ST_CAPTURE: w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered values line up with the state they describe.
    always_comb begin
        w_s_next      = S_HOLD;
        w_active_next = (w_state_next != ST_IDLE);
        case (w_state_next)
            ST_LOAD:  w_s_next = S_LOAD;
            ST_SHIFT: w_s_next = r_dir ? S_LEFT : S_RIGHT;
            default:  w_s_next = S_HOLD;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_dir    <= 1'b0;
            r_count  <= 3'd0;
            r_cnt    <= 3'd0;
            o_s      <= S_HOLD;
            o_d      <= 4'd0;
            o_oe     <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_result <= 4'd0;
        end else begin
            r_state <= w_state_next;
            o_s     <= w_s_next;
            o_oe    <= w_active_next;
            o_busy  <= w_active_next;
            o_done  <= (r_state == ST_CAPTURE);
            if (w_accept) begin
                o_d     <= i_din;
                r_dir   <= i_dir;
                r_count <= i_count;
            end
            if (r_state == ST_LOAD) begin
                r_cnt <= r_count;
            end else if (r_state == ST_SHIFT) begin
                r_cnt <= r_cnt - 3'd1;
            end
            if (r_state == ST_CAPTURE) begin
                o_result <= i_q;
            end
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: a 74194-style register closes the loop, and results are predicted arithmetically.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] din;
    logic       dir;
    logic [2:0] count;
    logic [3:0] q = 4'd0;
    logic [1:0] o_s;
    logic [3:0] o_d;
    logic       o_oe;
    logic       o_busy;
    logic       o_done;
    logic [3:0] o_result;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] exp_res  = 4'd0;

    always #5 clk = ~clk;

    shift_sequencer dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .i_din    (din),
        .i_dir    (dir),
        .i_count  (count),
        .i_q      (q),
        .o_s      (o_s),
        .o_d      (o_d),
        .o_oe     (o_oe),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_result (o_result)
    );

    // Downstream universal shift register, serial inputs tied low.
    always @(posedge clk) begin
        case (o_s)
            2'b01:   q <= {1'b0, q[3:1]};
            2'b10:   q <= {q[2:0], 1'b0};
            2'b11:   q <= o_d;
            default: q <= q;
        endcase
    end

    function automatic logic [3:0] ref_result(input logic [3:0] d, input logic dr, input int n);
        logic [7:0] w;
        w = {4'b0000, d};
        if (dr) w = w << n;
        else    w = w >> n;
        return w[3:0];
    endfunction

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // mode 0: quiet START, noisy data; mode 1: random START/data while busy; mode 2: START held with DIN=1111.
    task automatic test_op(input logic [3:0] d, input logic dr, input logic [2:0] n,
                           input int mode, input string tag);
        logic [3:0] exp;
        logic [1:0] es;
        logic       eb;
        logic       ed;
        int         last;
        exp   = ref_result(d, dr, int'(n));
        last  = int'(n) + 3;
        start = 1'b1;
        din   = d;
        dir   = dr;
        count = n;
        @(posedge clk);
        @(negedge clk);
        for (int k = 1; k <= last; k++) begin
            es = (k == 1) ? 2'b11 : (k <= int'(n) + 1) ? (dr ? 2'b10 : 2'b01) : 2'b00;
            eb = (k < last);
            ed = (k == last);
            n_checks++;
            if ({o_s, o_oe, o_busy, o_done} !== {es, eb, eb, ed}) begin
                n_fail++;
                $display("FAIL %s ctl cycle %0d: got s=%b oe=%b busy=%b done=%b, want s=%b oe=%b busy=%b done=%b",
                         tag, k, o_s, o_oe, o_busy, o_done, es, eb, eb, ed);
            end
            n_checks++;
            if (o_d !== d) begin
                n_fail++;
                $display("FAIL %s d cycle %0d: got %b, want %b", tag, k, o_d, d);
            end
            n_checks++;
            if (o_result !== ((k == last) ? exp : exp_res)) begin
                n_fail++;
                $display("FAIL %s result cycle %0d: got %b, want %b", tag, k, o_result,
                         (k == last) ? exp : exp_res);
            end
            if (k < last) begin
                case (mode)
                    0: begin
                        start = 1'b0;
                        din   = 4'($urandom);
                        dir   = 1'($urandom);
                        count = 3'($urandom);
                    end
                    1: begin
                        start = 1'($urandom);
                        din   = 4'($urandom);
                        dir   = 1'($urandom);
                        count = 3'($urandom);
                    end
                    default: begin
                        start = 1'b1;
                        din   = 4'hF;
                    end
                endcase
                @(negedge clk);
            end
        end
        exp_res = exp;
        start   = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        din   = 4'hF;
        dir   = 1'b1;
        count = 3'd7;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if ({o_s, o_d, o_oe, o_busy, o_done, o_result} !== 15'd0) begin
                n_fail++;
                $display("FAIL reset_hold: got s=%b d=%b oe=%b busy=%b done=%b result=%b, want all zero",
                         o_s, o_d, o_oe, o_busy, o_done, o_result);
            end
        end
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({o_s, o_oe, o_busy, o_done} !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_idle: got s=%b oe=%b busy=%b done=%b, want 00 0 0 0", o_s, o_oe, o_busy, o_done);
        end
        exp_res = 4'd0;
    endtask

    task automatic test_directed();
        test_op(4'b1010, 1'b1, 3'd1, 0, "left1");
        idle(2);
        test_op(4'b1010, 1'b0, 3'd2, 0, "right2");
        idle(1);
        test_op(4'b1010, 1'b1, 3'd0, 0, "count0");
        idle(2);
    endtask

    task automatic test_back_to_back();
        test_op(4'b1010, 1'b0, 3'd2, 2, "ignore_start");
        test_op(4'b0110, 1'b1, 3'd3, 0, "b2b_second");
        test_op(4'b1001, 1'b0, 3'd7, 1, "b2b_third");
        idle(2);
    endtask

    task automatic test_reset_midop();
        start = 1'b1;
        din   = 4'b1011;
        dir   = 1'b0;
        count = 3'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({o_s, o_d, o_oe, o_busy, o_done, o_result} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_midop: got s=%b d=%b oe=%b busy=%b done=%b result=%b, want all zero",
                     o_s, o_d, o_oe, o_busy, o_done, o_result);
        end
        rst     = 1'b0;
        exp_res = 4'd0;
        repeat (8) begin
            @(negedge clk);
            n_checks++;
            if ({o_busy, o_done, o_result} !== 6'd0) begin
                n_fail++;
                $display("FAIL reset_discard: got busy=%b done=%b result=%b, want 0 0 0000",
                         o_busy, o_done, o_result);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        test_op(4'b0011, 1'b1, 3'd2, 1, "after_reset");
        idle(2);
    endtask

    task automatic test_random();
        logic [3:0] d;
        logic       dr;
        logic [2:0] n;
        repeat (40) begin
            d  = 4'($urandom);
            dr = 1'($urandom);
            n  = 3'($urandom);
            test_op(d, dr, n, int'($urandom_range(0, 1)), "random");
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
